// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: Tuse/Tnew data hazards,
// mult/div busy tracking and a halt/drain state machine driving the
// pipeline-register write enables and the D-E bubble clear.
module pipe_hazard_ctrl #(
    parameter int unsigned MULT_LAT  = 5,
    parameter int unsigned DIV_LAT   = 10,
    parameter int unsigned DRAIN_CYC = 4
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic [4:0]  D_rs,
    input  logic [4:0]  D_rt,
    input  logic [1:0]  D_Tuse_rs,
    input  logic [1:0]  D_Tuse_rt,
    input  logic        D_is_md,
    input  logic [4:0]  E_A3,
    input  logic [1:0]  E_Tnew,
    input  logic [4:0]  M_A3,
    input  logic [1:0]  M_Tnew,
    input  logic        E_md_start,
    input  logic        E_md_div,
    input  logic        Halt_req,
    output logic        F_We,
    output logic        D_We,
    output logic        E_Clr,
    output logic        M_We,
    output logic        W_We,
    output logic        Md_busy,
    output logic        Halted,
    output logic [31:0] Stall_cnt
);

    localparam int unsigned MD_MAX  = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
    localparam int unsigned MD_W    = $clog2(MD_MAX + 1);
    localparam int unsigned DR_W    = $clog2(DRAIN_CYC + 1);
    localparam int unsigned CNT_W   = 32;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [MD_W-1:0]   md_cnt, md_cnt_nxt;
    logic [DR_W-1:0]   drain_cnt, drain_cnt_nxt;
    logic              md_busy_q;
    logic              halted_q;
    logic [CNT_W-1:0]  stall_cnt;

    logic              data_stall_c;
    logic              md_stall_c;
    logic              stall_c;
    logic              f_we_c, d_we_c, e_clr_c;

    // A source conflicts when its producer's result arrives after it is needed.
    function automatic logic src_hazard(input logic [4:0] src, input logic [1:0] tuse,
                                        input logic [4:0] a3, input logic [1:0] tnew);
        return (src != 5'd0) && (src == a3) && (tuse < tnew);
    endfunction

    // Hazard detection for the instruction sitting in D.
    always_comb begin
        data_stall_c = src_hazard(D_rs, D_Tuse_rs, E_A3, E_Tnew)
                     | src_hazard(D_rs, D_Tuse_rs, M_A3, M_Tnew)
                     | src_hazard(D_rt, D_Tuse_rt, E_A3, E_Tnew)
                     | src_hazard(D_rt, D_Tuse_rt, M_A3, M_Tnew);
        md_stall_c   = D_is_md & (md_busy_q | E_md_start);
        stall_c      = data_stall_c | md_stall_c;
    end

    // Mult/div occupancy: a start while already busy does not reload.
    always_comb begin
        md_cnt_nxt = md_cnt;
        if (md_cnt != '0) begin
            md_cnt_nxt = md_cnt - MD_W'(1);
        end else if (E_md_start) begin
            md_cnt_nxt = E_md_div ? MD_W'(DIV_LAT) : MD_W'(MULT_LAT);
        end
    end

    // Halt/drain next state and stage enables; reset forces the idle pattern.
    always_comb begin
        state_nxt     = state;
        drain_cnt_nxt = drain_cnt;
        f_we_c        = ~stall_c;
        d_we_c        = ~stall_c;
        e_clr_c       = stall_c;
        case (state)
            ST_RUN: begin
                if (Halt_req) begin
                    state_nxt     = ST_DRAIN;
                    drain_cnt_nxt = DR_W'(DRAIN_CYC);
                end
            end
            ST_DRAIN: begin
                f_we_c  = 1'b0;
                d_we_c  = 1'b0;
                e_clr_c = 1'b1;
                if (!Halt_req) begin
                    state_nxt = ST_RUN;
                end else if (drain_cnt <= DR_W'(1)) begin
                    state_nxt     = ST_HALTED;
                    drain_cnt_nxt = '0;
                end else begin
                    drain_cnt_nxt = drain_cnt - DR_W'(1);
                end
            end
            ST_HALTED: begin
                f_we_c  = 1'b0;
                d_we_c  = 1'b0;
                e_clr_c = 1'b1;
                if (!Halt_req) begin
                    state_nxt = ST_RUN;
                end
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase
        if (!Rst_n) begin
            f_we_c  = 1'b0;
            d_we_c  = 1'b0;
            e_clr_c = 1'b1;
        end
    end

    // State, counters and registered status outputs.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state     <= ST_RUN;
            md_cnt    <= '0;
            drain_cnt <= '0;
            md_busy_q <= 1'b0;
            halted_q  <= 1'b0;
            stall_cnt <= '0;
        end else begin
            state     <= state_nxt;
            md_cnt    <= md_cnt_nxt;
            drain_cnt <= drain_cnt_nxt;
            md_busy_q <= (md_cnt_nxt != '0);
            halted_q  <= (state_nxt == ST_HALTED);
            if ((state == ST_RUN) && stall_c) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

    assign F_We      = f_we_c;
    assign D_We      = d_we_c;
    assign E_Clr     = e_clr_c;
    assign M_We      = 1'b1;
    assign W_We      = 1'b1;
    assign Md_busy   = md_busy_q;
    assign Halted    = halted_q;
    assign Stall_cnt = stall_cnt;

endmodule
